// File: rtl/spin_pkg.sv
// Shared definitions for the spinner wheel initiator: FSM encodings and LFSR feedback.
package spin_pkg;

  typedef enum logic [1:0] {
    ST_SPIN  = 2'd0,
    ST_BRAKE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Feedback taps for x^4 + x^3 + 1 (bits 3 and 2 of the shift register).
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spin_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a stable-level counter.
module btn_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt_q;

  // Stage p0/p1: bring the raw button into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_i;
      sync_p1 <= sync_p0;
    end
  end

  // Level follows the synchronized input only after DEB_CYCLES disagreeing cycles in a row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_o <= 1'b0;
    end else if (sync_p1 != level_o) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_o <= sync_p1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/spin_ctrl.sv
// Spinner wheel initiator: debounced stop request, tick generator with brake ramp, and LFSR offset source.
module spin_ctrl
  import spin_pkg::*;
#(
  parameter int         PER_W      = 8,
  parameter int         TICK_FAST  = 4,
  parameter int         TICK_SLOW  = 16,
  parameter int         TICK_STEP  = 4,
  parameter int         DEB_CYCLES = 3,
  parameter logic [3:0] LFSR_SEED  = 4'h1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       running_i,
  output logic       tick_o,
  output logic       stop_o,
  output logic [3:0] rand_o
);

  localparam logic [3:0]       SEED   = (LFSR_SEED == 4'h0) ? 4'h1 : LFSR_SEED;
  localparam logic [PER_W-1:0] P_FAST = PER_W'(TICK_FAST);
  localparam logic [PER_W:0]   P_SLOW = (PER_W + 1)'(TICK_SLOW);
  localparam logic [PER_W:0]   P_STEP = (PER_W + 1)'(TICK_STEP);

  // Brake increment, computed one bit wider so it clamps instead of wrapping.
  function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] p);
    logic [PER_W:0] s;
    s = {1'b0, p} + P_STEP;
    if (s > P_SLOW) s = P_SLOW;
    return s[PER_W-1:0];
  endfunction

  state_t           state_q;
  state_t           state_n;
  logic [PER_W-1:0] cnt_q;
  logic [PER_W-1:0] cnt_n;
  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] period_n;
  logic             wrap;
  logic             tick_n;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i),
    .level_o(stop_o)
  );

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_SPIN:  if (!running_i) state_n = ST_HALT;
                else if (stop_o) state_n = ST_BRAKE;
      ST_BRAKE: if (!running_i) state_n = ST_HALT;
                else if (!stop_o) state_n = ST_SPIN;
      ST_HALT:  if (running_i && !stop_o) state_n = ST_SPIN;
      default:  state_n = ST_SPIN;
    endcase

    // Period only changes at the wrap so an interval is never cut short; a brake
    // step needs a tick seen while already braking.
    wrap     = (cnt_q == period_q - PER_W'(1));
    cnt_n    = wrap ? '0 : cnt_q + PER_W'(1);
    period_n = period_q;
    if (wrap) begin
      case (state_n)
        ST_SPIN:  period_n = P_FAST;
        ST_BRAKE: if (state_q == ST_BRAKE) period_n = sat_inc(period_q);
        default:  period_n = period_q;
      endcase
    end
    tick_n = (cnt_n == period_n - PER_W'(1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_SPIN;
      cnt_q    <= '0;
      period_q <= P_FAST;
      tick_o   <= 1'b0;
      rand_o   <= SEED;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      period_q <= period_n;
      tick_o   <= tick_n;
      rand_o   <= lfsr_next(rand_o);
    end
  end

endmodule

// File: tb/tb_spin_ctrl.sv
// Directed bench for spin_ctrl: reset, free spin, debounce, brake ramp, halt, restart and brake abort.
module tb_spin_ctrl;
  import spin_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       running = 1'b1;
  logic       tick;
  logic       stop;
  logic [3:0] rnd;

  int checks = 0;
  int errors = 0;

  spin_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_i    (btn),
    .running_i(running),
    .tick_o   (tick),
    .stop_o   (stop),
    .rand_o   (rnd)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lfsr_model(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, tick}, 1);
  endtask

  task automatic measure(input string tag, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 64);
    chk(tag, n, exp);
  endtask

  task automatic expect_stop_after5(input string tag, input logic lvl);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) chk({tag, "_early"}, {31'b0, stop}, {31'b0, ~lvl});
      if (k == 5) chk(tag, {31'b0, stop}, {31'b0, lvl});
    end
  endtask

  initial begin
    logic [3:0] r [16];
    int         c;
    logic       any;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_tick", {31'b0, tick}, 0);
    chk("rst_stop", {31'b0, stop}, 0);
    chk("rst_rand", {28'b0, rnd}, 1);
    chk("rst_state", {30'b0, dut.state_q}, {30'b0, ST_SPIN});
    rst = 1'b0;
    c = 1;
    while (tick !== 1'b1 && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk("first_tick_cycle", c, 4);

    // Free spin
    for (int i = 0; i < 8; i++) measure("spin_interval", 4);
    for (int i = 0; i < 16; i++) begin
      r[i] = rnd;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) chk("rand_nonzero", {31'b0, r[i] != 4'h0}, 1);
    for (int i = 0; i < 15; i++) chk("rand_step", {28'b0, r[i+1]}, {28'b0, lfsr_model(r[i])});
    any = 1'b0;
    for (int i = 1; i < 15; i++) if (r[i] == r[0]) any = 1'b1;
    chk("rand_no_short_period", {31'b0, any}, 0);
    chk("rand_period15", {28'b0, r[15]}, {28'b0, r[0]});

    // Asynchronous reset in the middle of a tick cycle
    wait_tick("pre_reset_tick");
    rst = 1'b1;
    #1;
    chk("async_rst_tick", {31'b0, tick}, 0);
    chk("async_rst_rand", {28'b0, rnd}, 1);
    @(negedge clk);
    rst = 1'b0;
    c = 1;
    while (tick !== 1'b1 && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk("first_tick_after_rst", c, 4);

    // Debounce: short glitch is ignored, clean press lands after 5 cycles
    @(negedge clk);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (stop !== 1'b0) any = 1'b1;
    end
    chk("glitch_stop", {31'b0, any}, 0);

    wait_tick("align_press");
    btn = 1'b1;
    expect_stop_after5("press_stop", 1'b1);

    // Brake ramp, then wheel stops
    wait_tick("brake_t0");
    measure("brake_interval_8", 8);
    measure("brake_interval_12", 12);
    measure("brake_interval_16", 16);
    measure("brake_interval_sat", 16);
    measure("brake_interval_sat2", 16);
    running = 1'b0;
    measure("halt_interval", 16);
    measure("halt_interval2", 16);
    chk("halt_state", {30'b0, dut.state_q}, {30'b0, ST_HALT});

    // Restart from HALT
    btn = 1'b0;
    expect_stop_after5("release_stop", 1'b0);
    chk("halt_held", {30'b0, dut.state_q}, {30'b0, ST_HALT});
    running = 1'b1;
    wait_tick("restart_t0");
    measure("restart_interval", 4);
    measure("restart_interval2", 4);
    chk("restart_state", {30'b0, dut.state_q}, {30'b0, ST_SPIN});

    // Abort a brake while the wheel keeps running
    btn = 1'b1;
    expect_stop_after5("abort_press_stop", 1'b1);
    wait_tick("abort_t0");
    measure("abort_brake_interval", 8);
    btn = 1'b0;
    expect_stop_after5("abort_stop", 1'b0);
    wait_tick("abort_t1");
    measure("abort_interval", 4);
    chk("abort_state", {30'b0, dut.state_q}, {30'b0, ST_SPIN});

    // Reset while braking clears the stop request immediately
    btn = 1'b1;
    expect_stop_after5("rebrake_stop", 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_stop", {31'b0, stop}, 0);
    chk("async_rst_state", {30'b0, dut.state_q}, {30'b0, ST_SPIN});
    chk("async_rst_tick2", {31'b0, tick}, 0);
    btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
